// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, framer state encoding and CRC helpers.
// CRC constants are kept in their conventional MSB-first form.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData,
        StDrop
    } rx_state_e;

    // The shift register runs LSB-first, so the MSB-first constants are mirrored.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_framer_if.sv
// Nibble-wide receive input and byte-wide framed output of the receive framer.
interface rx_framer_if;

    logic       ETH_RXCTRL;
    logic [3:0] ETH_RX;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_SOF;
    logic       RX_EOF;
    logic       RX_ERR;

    modport master (
        output ETH_RXCTRL, ETH_RX,
        input  RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_ERR
    );

    modport slave (
        input  ETH_RXCTRL, ETH_RX,
        output RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_ERR
    );

endinterface

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register; init has priority over enable.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        init,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    localparam logic [31:0] PolyRefl = reflect32(CRC32_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ PolyRefl) : (crc_d >> 1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q <= CRC32_INIT;
        end else if (init) begin
            crc_q <= CRC32_INIT;
        end else if (enable) begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rx_framer.sv
// Receive framer: strips preamble/SFD, assembles nibbles into bytes and emits
// them one byte late so the last byte can carry EOF and the frame verdict.
module rx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1522
) (
    input logic        ETH_RXCLK,
    input logic        RST,
    rx_framer_if.slave mii
);

    localparam int unsigned     CntW        = $clog2(MAX_LEN + 2);
    localparam logic [CntW-1:0] MinLenC     = CntW'(MIN_LEN);
    localparam logic [CntW-1:0] MaxLenC     = CntW'(MAX_LEN);
    localparam logic [31:0]     ResidueRefl = reflect32(CRC32_RESIDUE);

    rx_state_e       state_q, state_d;
    logic [1:0]      pre_cnt_q, pre_cnt_d;
    logic            phase_q, phase_d;
    logic [3:0]      low_q, low_d;
    logic [7:0]      held_q, held_d;
    logic            held_vld_q, held_vld_d;
    logic            held_sof_q, held_sof_d;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic            err_q, err_d;

    logic            ctrl;
    logic [3:0]      nib;
    logic            byte_done;
    logic [7:0]      byte_val;
    logic            crc_init;
    logic [31:0]     crc_val;

    assign ctrl     = mii.ETH_RXCTRL;
    assign nib      = mii.ETH_RX;
    assign byte_val = {nib, low_q};
    assign crc_init = (state_q != StData);

    crc32_d8 u_crc (
        .clock  (ETH_RXCLK),
        .reset  (RST),
        .init   (crc_init),
        .enable (byte_done),
        .data   (byte_val),
        .crc    (crc_val)
    );

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        phase_d    = phase_q;
        low_d      = low_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        held_sof_d = held_sof_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;
        byte_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                phase_d    = 1'b0;
                held_vld_d = 1'b0;
                byte_cnt_d = '0;
                pre_cnt_d  = 2'd0;
                if (ctrl) begin
                    if (nib == PREAMBLE_NIB) begin
                        state_d   = StPreamble;
                        pre_cnt_d = 2'd1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StPreamble: begin
                if (!ctrl) begin
                    state_d = StIdle;
                end else if (nib == PREAMBLE_NIB) begin
                    if (pre_cnt_q != 2'd3) pre_cnt_d = pre_cnt_q + 2'd1;
                end else if (nib == SFD_NIB && pre_cnt_q >= 2'd2) begin
                    state_d = StData;
                    phase_d = 1'b0;
                end else begin
                    state_d = StDrop;
                end
            end
            StData: begin
                if (!ctrl) begin
                    if (held_vld_q) begin
                        data_d  = held_q;
                        valid_d = 1'b1;
                        sof_d   = held_sof_q;
                        eof_d   = 1'b1;
                        err_d   = (crc_val != ResidueRefl) || (byte_cnt_q < MinLenC) || phase_q;
                    end
                    held_vld_d = 1'b0;
                    state_d    = StIdle;
                end else if (!phase_q) begin
                    low_d   = nib;
                    phase_d = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    byte_done = 1'b1;
                    if (held_vld_q) begin
                        data_d  = held_q;
                        valid_d = 1'b1;
                        sof_d   = held_sof_q;
                    end
                    // Byte MAX_LEN+1 just completed: close the frame on the held byte.
                    if (byte_cnt_q >= MaxLenC) begin
                        eof_d      = held_vld_q;
                        err_d      = held_vld_q;
                        held_vld_d = 1'b0;
                        byte_cnt_d = MaxLenC + CntW'(1);
                        state_d    = StDrop;
                    end else begin
                        held_d     = byte_val;
                        held_vld_d = 1'b1;
                        held_sof_d = (byte_cnt_q == '0);
                        byte_cnt_d = byte_cnt_q + CntW'(1);
                    end
                end
            end
            StDrop: begin
                if (!ctrl) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ETH_RXCLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            pre_cnt_q  <= 2'd0;
            phase_q    <= 1'b0;
            low_q      <= 4'h0;
            held_q     <= 8'h00;
            held_vld_q <= 1'b0;
            held_sof_q <= 1'b0;
            byte_cnt_q <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            phase_q    <= phase_d;
            low_q      <= low_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            held_sof_q <= held_sof_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
        end
    end

    assign mii.RX_DATA  = data_q;
    assign mii.RX_VALID = valid_q;
    assign mii.RX_SOF   = sof_q;
    assign mii.RX_EOF   = eof_q;
    assign mii.RX_ERR   = err_q;

endmodule

// File: tb/tb_rx_framer.sv
// Scoreboard bench for rx_framer: directed frames push expected bytes, a
// monitor pops and compares every RX_VALID strobe.
module tb_rx_framer;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    rx_framer_if mii ();

    rx_framer #(
        .MIN_LEN (64),
        .MAX_LEN (1522)
    ) dut (
        .ETH_RXCLK (clk),
        .RST       (rst),
        .mii       (mii)
    );

    exp_t       exp_q[$];
    logic [7:0] frm[0:1599];
    int         checks   = 0;
    int         failures = 0;
    int         strobes  = 0;

    initial clk = 1'b0;
    always #4 clk = ~clk;

    function automatic logic [31:0] crc_bitwise(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    // Payload pattern plus a correct little-endian FCS in the last four bytes.
    task automatic build_frame(input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len - 4; i++) begin
            frm[i] = 8'((i * 13 + 7) & 255);
            c      = crc_bitwise(c, frm[i]);
        end
        c = ~c;
        frm[len-4] = c[7:0];
        frm[len-3] = c[15:8];
        frm[len-2] = c[23:16];
        frm[len-1] = c[31:24];
    endtask

    task automatic expect_bytes(input int n, input logic eof, input logic err);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = frm[i];
            e.sof  = (i == 0);
            e.eof  = eof && (i == n - 1);
            e.err  = eof && (i == n - 1) && err;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        mii.ETH_RXCTRL = 1'b1;
        mii.ETH_RX     = n;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mii.ETH_RXCTRL = 1'b0;
            mii.ETH_RX     = 4'h0;
        end
    endtask

    task automatic send_preamble(input int n5);
        for (int i = 0; i < n5; i++) send_nib(4'h5);
        send_nib(4'hD);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            send_nib(frm[i][3:0]);
            send_nib(frm[i][7:4]);
        end
    endtask

    task automatic drain(input string name);
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected strobes never seen, want 0 outstanding", name,
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (mii.RX_DATA !== 8'h00 || mii.RX_VALID !== 1'b0 || mii.RX_SOF !== 1'b0 ||
            mii.RX_EOF !== 1'b0 || mii.RX_ERR !== 1'b0) begin
            failures++;
            $display("FAIL %s: got data=%h v=%b s=%b e=%b err=%b, want all zero", name,
                     mii.RX_DATA, mii.RX_VALID, mii.RX_SOF, mii.RX_EOF, mii.RX_ERR);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(posedge clk);
            #1;
            got = {mii.RX_DATA, mii.RX_SOF, mii.RX_EOF, mii.RX_ERR};
            if (mii.RX_VALID === 1'b1) begin
                strobes++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: got data=%h sof=%b eof=%b err=%b, want none",
                             got.data, got.sof, got.eof, got.err);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL strobe%0d: got data=%h sof=%b eof=%b err=%b, want data=%h sof=%b eof=%b err=%b",
                                 strobes, got.data, got.sof, got.eof, got.err, want.data,
                                 want.sof, want.eof, want.err);
                    end
                end
            end else if (rst === 1'b0) begin
                checks++;
                if (got.sof !== 1'b0 || got.eof !== 1'b0 || got.err !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_flags: got sof=%b eof=%b err=%b without RX_VALID, want 0",
                             got.sof, got.eof, got.err);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        mii.ETH_RXCTRL = 1'b0;
        mii.ETH_RX     = 4'h0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        idle(2);

        // Good 64-byte frame, then back-to-back bit-flipped copy after one idle cycle.
        build_frame(64);
        expect_bytes(64, 1'b1, 1'b0);
        send_preamble(15);
        send_bytes(64);
        idle(1);
        build_frame(64);
        frm[20] = frm[20] ^ 8'h10;
        expect_bytes(64, 1'b1, 1'b1);
        send_preamble(15);
        send_bytes(64);
        drain("good_then_bitflip");

        // Runt with valid FCS.
        build_frame(60);
        expect_bytes(60, 1'b1, 1'b1);
        send_preamble(15);
        send_bytes(60);
        drain("runt60");

        // Oversize: truncated at byte 1521, then a clean frame.
        build_frame(1600);
        expect_bytes(1522, 1'b1, 1'b1);
        send_preamble(15);
        send_bytes(1600);
        idle(1);
        build_frame(64);
        expect_bytes(64, 1'b1, 1'b0);
        send_preamble(15);
        send_bytes(64);
        drain("oversize_then_good");

        // Odd nibble count: good 64 bytes plus one stray nibble.
        build_frame(64);
        expect_bytes(64, 1'b1, 1'b1);
        send_preamble(15);
        send_bytes(64);
        send_nib(4'hA);
        drain("odd_nibble");

        // No output: CTRL drops before first byte completes; short preamble.
        send_preamble(15);
        send_nib(4'h3);
        idle(2);
        build_frame(64);
        send_preamble(1);
        send_bytes(64);
        drain("no_output_cases");

        // Reset after 30 bytes: bytes 0..28 already emitted, no EOF.
        build_frame(64);
        expect_bytes(29, 1'b0, 1'b0);
        send_preamble(15);
        send_bytes(30);
        @(negedge clk);
        rst            = 1'b1;
        mii.ETH_RXCTRL = 1'b0;
        mii.ETH_RX     = 4'h0;
        @(negedge clk);
        check_reset_outputs("reset_midframe");
        rst = 1'b0;
        drain("reset_midframe_drain");
        build_frame(64);
        expect_bytes(64, 1'b1, 1'b0);
        send_preamble(15);
        send_bytes(64);
        drain("good_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_framer.md
RX_FRAMER -- requirements
Module: rx_framer

Interface
REQ-001 Parameter MIN_LEN, default 64: minimum frame bytes (DA through FCS); shorter frames are flagged as errors.
REQ-002 Parameter MAX_LEN, default 1522: maximum frame bytes; longer frames are truncated and flagged.
REQ-003 ETH_RXCLK  in  1: sole clock, 125 MHz; all logic on the rising edge.
REQ-004 RST  in  1: asynchronous, active-high reset.
REQ-005 ETH_RXCTRL  in  1: receive data valid; one nibble per rising edge while high.
REQ-006 ETH_RX  in  4: receive nibble; low nibble of each byte arrives first.
REQ-007 RX_DATA  out  8: frame byte, DA through FCS.
REQ-008 RX_VALID  out  1: RX_DATA valid this cycle; single-cycle strobe with no backpressure.
REQ-009 RX_SOF  out  1: qualifies the first byte of a frame.
REQ-010 RX_EOF  out  1: qualifies the last byte of a frame.
REQ-011 RX_ERR  out  1: valid only with RX_EOF; high means the frame is bad.

Function
REQ-012 States SHALL be IDLE, PREAMBLE, DATA and DROP.
REQ-013 IDLE SHALL go to PREAMBLE when CTRL=1 and RX=0x5; CTRL=1 with any other nibble SHALL go to DROP.
REQ-014 PREAMBLE SHALL handle each nibble as follows:
- RX=0x5: stay and count.
- RX=0xD after at least 2 counted 0x5 nibbles: go to DATA with nibble phase=low.
- Any other nibble: go to DROP.
- CTRL=0: go to IDLE with no output.
REQ-015 DATA SHALL capture the low nibble on phase low and complete the byte {RX, low} on phase high, toggling phase on every CTRL=1 cycle.
REQ-016 Completed bytes SHALL be held one byte deep. When a byte completes and a held byte exists, the held byte SHALL be emitted on the next cycle with RX_VALID=1, and RX_SOF=1 if it is byte 0.
REQ-017 On CTRL=0 in DATA, the held byte SHALL be emitted on the next cycle with RX_EOF=1 and RX_ERR evaluated; the state SHALL then return to IDLE.
REQ-018 RX_ERR SHALL equal the OR of:
- CRC residue != 0xC704DD7B;
- byte count < MIN_LEN;
- odd nibble count, i.e. CTRL dropped with phase high (the partial nibble is discarded);
- length overflow.
REQ-019 The CRC SHALL be CRC-32, reflected, polynomial 0x04C11DB7, initial 0xFFFFFFFF, computed over every completed byte including the FCS, with no final inversion before the residue compare.
REQ-020 Length overflow: when byte MAX_LEN+1 completes, the held byte SHALL be emitted with RX_EOF=1 and RX_ERR=1, and the state SHALL go to DROP.
REQ-021 DROP SHALL ignore input until CTRL=0, then go to IDLE.
REQ-022 A frame that ends with no held byte (CTRL drop before the first byte completes) SHALL produce no output.
REQ-023 RX_VALID, RX_SOF, RX_EOF and RX_ERR SHALL be single-cycle pulses, low in every cycle without a strobe.
REQ-024 Back-to-back frames with one CTRL=0 cycle between them SHALL be handled: the EOF of frame N and the PREAMBLE entry of frame N+1 coexist without loss.
REQ-025 The byte counter SHALL saturate at MAX_LEN+1 and SHALL NOT wrap.

Reset
REQ-026 While RST=1, the block SHALL hold:
- state=IDLE;
- RX_DATA=0x00;
- RX_VALID, RX_SOF, RX_EOF, RX_ERR = 0;
- CRC register=0xFFFFFFFF;
- counters and held-byte flag = 0.
REQ-027 Reset mid-frame SHALL discard the frame with no EOF; after release, the first frame SHALL be accepted only once a fresh preamble is seen.

Structure
REQ-028 A shared package eth_pkg SHALL hold:
- CRC32_POLY, CRC32_INIT and CRC32_RESIDUE;
- the preamble nibble 0x5 and SFD nibble 0xD;
- the state encoding.
REQ-029 The byte-wise CRC update SHALL be a sub-module crc32_d8 with ports clock, reset, init, enable, data[7:0] and crc[31:0].

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Valid 64-byte frame with correct FCS after 15×0x5 + 0xD -> 64 RX_VALID strobes, SOF on byte 0, EOF on byte 63, RX_ERR=0.
- Same frame with one payload bit flipped -> EOF with RX_ERR=1, all 64 bytes still output.
- 60-byte frame with correct CRC -> EOF with RX_ERR=1 (runt).
- 1600-byte frame -> exactly 1522 strobes, EOF+ERR on byte 1521, nothing further until CTRL=0, next frame received cleanly.
- Frame ending on an odd nibble (129 nibbles) -> 64 bytes output, EOF with RX_ERR=1.
- RST pulsed at byte 30 of a frame, then a good frame -> no EOF for the first frame, second frame passes with RX_ERR=0.
